// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sequencer: default widths and state encoding.
package fir_pkg;

    localparam int unsigned FIR_DATA_W = 8;
    localparam int unsigned FIR_N_TAPS = 8;
    localparam int unsigned FIR_ADDR_W = 3;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RUN   = 2'd2
    } fir_state_e;

endpackage

// File: rtl/fir_ctrl.sv
// fir_ctrl: sequencer and circular sample-buffer controller for an N_TAPS FIR.
// Zeroes the sample RAM after reset, accepts samples on a valid/ready
// handshake, writes them into the RAM, and for every accepted sample walks
// N_TAPS cycles of coefficient-ROM / sample-RAM read addresses for the MAC.
//
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   x_valid, x_in, x_ready input sample handshake
//   ram_we/ram_waddr/ram_wdata  sample RAM write port (write lands at the edge)
//   ram_raddr              sample RAM read address (asynchronous read RAM)
//   rom_addr               coefficient ROM address (asynchronous read ROM)
//   mac_init               high on tap 0 of a frame
//   busy                   high while clearing or running a frame
//   frame_done             high during the last tap of a frame
module fir_ctrl
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W = FIR_DATA_W,
    parameter int unsigned N_TAPS = FIR_N_TAPS,
    parameter int unsigned ADDR_W = FIR_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              x_valid,
    input  logic [DATA_W-1:0] x_in,
    output logic              x_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              mac_init,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_TAPS - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    fir_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0] tap_q, tap_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;

    logic last_tap;
    logic accept;

    // Ready in IDLE and on the last tap so frames can run back to back.
    assign last_tap = (state_q == ST_RUN) && (tap_q == LAST_IDX);
    assign x_ready  = (state_q == ST_IDLE) || last_tap;
    assign accept   = x_valid & x_ready;

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        tap_d      = tap_q;
        wptr_d     = wptr_q;
        ram_we     = 1'b0;
        ram_waddr  = '0;
        ram_wdata  = '0;
        ram_raddr  = '0;
        rom_addr   = '0;
        mac_init   = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                busy      = 1'b1;
                ram_we    = 1'b1;
                ram_waddr = clr_cnt_q;
                // Wraps back to zero on the final clear cycle.
                clr_cnt_d = clr_cnt_q + ONE;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
            end
            ST_RUN: begin
                busy       = 1'b1;
                rom_addr   = tap_q;
                // Tap k pairs h[k] with x[n-k]; wraps naturally mod N_TAPS.
                ram_raddr  = wptr_q - tap_q;
                mac_init   = (tap_q == '0);
                frame_done = last_tap;
                tap_d      = tap_q + ONE;
                if (last_tap) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        // On the last tap the write target is the oldest sample, which is
        // being read this same cycle; the async read sees the old value.
        if (accept) begin
            ram_we    = 1'b1;
            ram_waddr = wptr_q + ONE;
            ram_wdata = x_in;
            wptr_d    = wptr_q + ONE;
            tap_d     = '0;
            state_d   = ST_RUN;
        end
    end

    // State and counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            tap_q     <= '0;
            wptr_q    <= LAST_IDX;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            tap_q     <= tap_d;
            wptr_q    <= wptr_d;
        end
    end

endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: directed testbench for fir_ctrl with a behavioural sample
// RAM, coefficient ROM h = {1..8} and MAC accumulator around the DUT.
module tb_fir_ctrl;

    logic       clock;
    logic       reset;
    logic       x_valid;
    logic [7:0] x_in;
    logic       x_ready;
    logic       ram_we;
    logic [2:0] ram_waddr;
    logic [7:0] ram_wdata;
    logic [2:0] ram_raddr;
    logic [2:0] rom_addr;
    logic       mac_init;
    logic       busy;
    logic       frame_done;

    int n_checks;
    int n_fail;

    logic [7:0] mem [8];
    int         h [8] = '{1, 2, 3, 4, 5, 6, 7, 8};

    fir_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .x_valid    (x_valid),
        .x_in       (x_in),
        .x_ready    (x_ready),
        .ram_we     (ram_we),
        .ram_waddr  (ram_waddr),
        .ram_wdata  (ram_wdata),
        .ram_raddr  (ram_raddr),
        .rom_addr   (rom_addr),
        .mac_init   (mac_init),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // External sample RAM: synchronous write, asynchronous read.
    always @(posedge clock) begin
        if (!reset && ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

    // Apply inputs at the falling edge and let the decode settle.
    task automatic drive(input logic v, input logic [7:0] d);
        @(negedge clock);
        x_valid = v;
        x_in    = d;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset   = 1'b1;
        x_valid = 1'b0;
        x_in    = 8'd0;
        #1;
        n_checks++; if (x_ready !== 1'b0) begin n_fail++; $display("FAIL rst_x_ready got %b want 0", x_ready); end
        n_checks++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL rst_ram_we got %b want 1", ram_we); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy got %b want 1", busy); end
        n_checks++; if (mac_init !== 1'b0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_pulses got mac_init=%b frame_done=%b want 0 0", mac_init, frame_done); end
        n_checks++; if (ram_waddr !== 3'd0 || ram_wdata !== 8'd0 || ram_raddr !== 3'd0 || rom_addr !== 3'd0) begin
            n_fail++; $display("FAIL rst_addrs got waddr=%0d wdata=%0d raddr=%0d rom=%0d want all 0", ram_waddr, ram_wdata, ram_raddr, rom_addr);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) drive(1'b0, 8'd0);
            n_checks++; if (ram_we !== 1'b1 || ram_waddr !== 3'(i) || ram_wdata !== 8'd0) begin
                n_fail++; $display("FAIL clear_write cyc %0d got we=%b addr=%0d data=%0d want 1 %0d 0", i, ram_we, ram_waddr, ram_wdata, i);
            end
            n_checks++; if (x_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++; $display("FAIL clear_status cyc %0d got ready=%b busy=%b want 0 1", i, x_ready, busy);
            end
        end
        drive(1'b0, 8'd0);
        n_checks++; if (x_ready !== 1'b1 || busy !== 1'b0 || ram_we !== 1'b0) begin
            n_fail++; $display("FAIL idle_entry got ready=%b busy=%b we=%b want 1 0 0", x_ready, busy, ram_we);
        end
    endtask

    task automatic test_single();
        int exp_rd [8] = '{0, 7, 6, 5, 4, 3, 2, 1};
        drive(1'b1, 8'd5);
        n_checks++; if (ram_we !== 1'b1 || ram_waddr !== 3'd0 || ram_wdata !== 8'd5) begin
            n_fail++; $display("FAIL single_write got we=%b addr=%0d data=%0d want 1 0 5", ram_we, ram_waddr, ram_wdata);
        end
        n_checks++; if (mac_init !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_idle got mac_init=%b busy=%b want 0 0", mac_init, busy);
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 8'd0);
            n_checks++; if (rom_addr !== 3'(k) || ram_raddr !== 3'(exp_rd[k])) begin
                n_fail++; $display("FAIL single_addr tap %0d got rom=%0d raddr=%0d want %0d %0d", k, rom_addr, ram_raddr, k, exp_rd[k]);
            end
            n_checks++; if (mac_init !== (k == 0) || frame_done !== (k == 7) || x_ready !== (k == 7)) begin
                n_fail++; $display("FAIL single_ctl tap %0d got init=%b done=%b ready=%b", k, mac_init, frame_done, x_ready);
            end
            n_checks++; if (busy !== 1'b1 || ram_we !== 1'b0) begin
                n_fail++; $display("FAIL single_busy tap %0d got busy=%b we=%b want 1 0", k, busy, ram_we);
            end
        end
        drive(1'b0, 8'd0);
        n_checks++; if (busy !== 1'b0 || x_ready !== 1'b1 || mac_init !== 1'b0) begin
            n_fail++; $display("FAIL single_end got busy=%b ready=%b init=%b want 0 1 0", busy, x_ready, mac_init);
        end
    endtask

    task automatic test_stream();
        int exp_rd [3][8] = '{'{0, 7, 6, 5, 4, 3, 2, 1},
                              '{1, 0, 7, 6, 5, 4, 3, 2},
                              '{2, 1, 0, 7, 6, 5, 4, 3}};
        drive(1'b1, 8'd1);
        n_checks++; if (ram_we !== 1'b1 || ram_waddr !== 3'd0 || ram_wdata !== 8'd1) begin
            n_fail++; $display("FAIL stream_first got we=%b addr=%0d data=%0d want 1 0 1", ram_we, ram_waddr, ram_wdata);
        end
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 8; k++) begin
                drive(f < 2, 8'(f + 2));
                n_checks++; if (mac_init !== (k == 0) || rom_addr !== 3'(k) || ram_raddr !== 3'(exp_rd[f][k])) begin
                    n_fail++; $display("FAIL stream_tap f%0d k%0d got init=%b rom=%0d raddr=%0d want raddr %0d", f, k, mac_init, rom_addr, ram_raddr, exp_rd[f][k]);
                end
                if (k == 7 && f < 2) begin
                    n_checks++; if (ram_we !== 1'b1 || ram_waddr !== 3'(f + 1) || ram_wdata !== 8'(f + 2) || frame_done !== 1'b1) begin
                        n_fail++; $display("FAIL stream_write f%0d got we=%b addr=%0d data=%0d done=%b want 1 %0d %0d 1", f, ram_we, ram_waddr, ram_wdata, frame_done, f + 1, f + 2);
                    end
                end else begin
                    n_checks++; if (ram_we !== 1'b0) begin
                        n_fail++; $display("FAIL stream_nowrite f%0d k%0d got we=%b want 0", f, k, ram_we);
                    end
                end
            end
        end
        drive(1'b0, 8'd0);
        n_checks++; if (busy !== 1'b0 || x_ready !== 1'b1) begin
            n_fail++; $display("FAIL stream_end got busy=%b ready=%b want 0 1", busy, x_ready);
        end
    endtask

    task automatic test_nine();
        int exp_y  [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 0};
        int exp_rd [8] = '{0, 7, 6, 5, 4, 3, 2, 1};
        int acc;
        int prod;
        acc = 0;
        drive(1'b1, 8'd1);
        n_checks++; if (ram_we !== 1'b1 || ram_waddr !== 3'd0 || ram_wdata !== 8'd1) begin
            n_fail++; $display("FAIL nine_first got we=%b addr=%0d data=%0d want 1 0 1", ram_we, ram_waddr, ram_wdata);
        end
        for (int s = 0; s < 9; s++) begin
            for (int k = 0; k < 8; k++) begin
                drive(k == 7 && s < 8, 8'd0);
                prod = h[rom_addr] * int'(mem[ram_raddr]);
                acc  = mac_init ? prod : acc + prod;
                if (s == 8) begin
                    n_checks++; if (ram_raddr !== 3'(exp_rd[k])) begin
                        n_fail++; $display("FAIL nine_raddr tap %0d got %0d want %0d", k, ram_raddr, exp_rd[k]);
                    end
                end
                if (s == 7 && k == 7) begin
                    n_checks++; if (ram_we !== 1'b1 || ram_waddr !== 3'd0) begin
                        n_fail++; $display("FAIL nine_wrap_write got we=%b addr=%0d want 1 0", ram_we, ram_waddr);
                    end
                end
                if (k == 7) begin
                    n_checks++; if (acc !== exp_y[s]) begin
                        n_fail++; $display("FAIL nine_y sample %0d got %0d want %0d", s, acc, exp_y[s]);
                    end
                end
            end
        end
        drive(1'b0, 8'd0);
        n_checks++; if (busy !== 1'b0) begin
            n_fail++; $display("FAIL nine_end got busy=%b want 0", busy);
        end
    endtask

    task automatic test_valid_pulse();
        drive(1'b1, 8'd9);
        n_checks++; if (ram_we !== 1'b1 || ram_waddr !== 3'd0 || ram_wdata !== 8'd9) begin
            n_fail++; $display("FAIL pulse_first got we=%b addr=%0d data=%0d want 1 0 9", ram_we, ram_waddr, ram_wdata);
        end
        for (int k = 0; k < 8; k++) begin
            drive(k < 7, 8'h55);
            n_checks++; if (ram_we !== 1'b0 || x_ready !== (k == 7)) begin
                n_fail++; $display("FAIL pulse_block tap %0d got we=%b ready=%b", k, ram_we, x_ready);
            end
            n_checks++; if (rom_addr !== 3'(k) || mac_init !== (k == 0) || frame_done !== (k == 7)) begin
                n_fail++; $display("FAIL pulse_seq tap %0d got rom=%0d init=%b done=%b", k, rom_addr, mac_init, frame_done);
            end
        end
        drive(1'b0, 8'd0);
        n_checks++; if (busy !== 1'b0 || x_ready !== 1'b1 || mem[1] !== 8'd0) begin
            n_fail++; $display("FAIL pulse_end got busy=%b ready=%b mem1=%0d want 0 1 0", busy, x_ready, mem[1]);
        end
    endtask

    task automatic test_reset_mid_run();
        drive(1'b1, 8'd4);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 8'd4);
            n_checks++; if (rom_addr !== 3'(k) || busy !== 1'b1) begin
                n_fail++; $display("FAIL midrst_pre tap %0d got rom=%0d busy=%b", k, rom_addr, busy);
            end
        end
        reset = 1'b1;
        #1;
        n_checks++; if (mac_init !== 1'b0 || x_ready !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++; $display("FAIL midrst_ctl got init=%b ready=%b done=%b want 0 0 0", mac_init, x_ready, frame_done);
        end
        n_checks++; if (rom_addr !== 3'd0 || ram_raddr !== 3'd0 || ram_we !== 1'b1 || ram_waddr !== 3'd0) begin
            n_fail++; $display("FAIL midrst_addr got rom=%0d raddr=%0d we=%b waddr=%0d want 0 0 1 0", rom_addr, ram_raddr, ram_we, ram_waddr);
        end
        test_reset();
        drive(1'b1, 8'd6);
        n_checks++; if (ram_we !== 1'b1 || ram_waddr !== 3'd0 || ram_wdata !== 8'd6) begin
            n_fail++; $display("FAIL midrst_next got we=%b addr=%0d data=%0d want 1 0 6", ram_we, ram_waddr, ram_wdata);
        end
        drive(1'b0, 8'd0);
        n_checks++; if (mac_init !== 1'b1 || ram_raddr !== 3'd0) begin
            n_fail++; $display("FAIL midrst_tap0 got init=%b raddr=%0d want 1 0", mac_init, ram_raddr);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        x_valid  = 1'b0;
        x_in     = 8'd0;
        for (int i = 0; i < 8; i++) mem[i] = 8'hAA;

        test_reset();
        test_single();
        test_reset();
        test_stream();
        test_reset();
        test_nine();
        test_reset();
        test_valid_pulse();
        test_reset();
        test_reset_mid_run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
